// File: rtl/bus_demux4.sv
// bus_demux4: routes one initiator request stream to one of four address-selected
// targets, keeps responses in order and answers out-of-range addresses locally.
module bus_demux4 #(
  parameter int SEL_LSB   = 28,
  parameter int MAX_OUTST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_we,
  input  logic [31:0]  req_wdata,
  input  logic [3:0]   req_be,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_err,
  output logic [3:0]   t_req_valid,
  input  logic [3:0]   t_req_ready,
  output logic [31:0]  t_addr,
  output logic         t_we,
  output logic [31:0]  t_wdata,
  output logic [3:0]   t_be,
  input  logic [3:0]   t_rsp_valid,
  output logic [3:0]   t_rsp_ready,
  input  logic [127:0] t_rsp_rdata,
  output logic         err_spurious
);

  localparam int         HI_SHIFT = SEL_LSB + 2;
  localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTST);

  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cur_sel_q, cur_sel_d;
  logic       err_pend_q, err_pend_d;
  logic       err_spurious_q, err_spurious_d;

  logic [1:0] sel_s;
  logic       in_range_s;
  logic       can_issue_s;
  logic       req_acc_s;
  logic       rsp_hs_s;
  logic       spur_hit_s;

  assign sel_s      = req_addr[SEL_LSB+1:SEL_LSB];
  // Shifting out every bit (SEL_LSB = 30) yields zero, so all addresses decode in range.
  assign in_range_s = ((req_addr >> HI_SHIFT) == 32'd0);

  assign t_addr       = req_addr;
  assign t_we         = req_we;
  assign t_wdata      = req_wdata;
  assign t_be         = req_be;
  assign err_spurious = err_spurious_q;

  // Request decode: a new target may only be issued once all older responses are back.
  always_comb begin
    t_req_valid = 4'b0000;
    req_ready   = 1'b0;
    can_issue_s = !err_pend_q && (cnt_q < MAX_CNT) &&
                  ((cnt_q == 4'd0) || (sel_s == cur_sel_q));
    if (in_range_s) begin
      t_req_valid[sel_s] = req_valid && can_issue_s;
      req_ready          = can_issue_s && t_req_ready[sel_s];
    end else begin
      req_ready = !err_pend_q && (cnt_q == 4'd0);
    end
  end

  // Response routing from the owed target, or the locally generated error response.
  always_comb begin
    rsp_valid   = 1'b0;
    rsp_rdata   = 32'd0;
    rsp_err     = 1'b0;
    t_rsp_ready = 4'b0000;
    if (cnt_q != 4'd0) begin
      rsp_valid              = t_rsp_valid[cur_sel_q];
      rsp_rdata              = t_rsp_rdata[{cur_sel_q, 5'd0} +: 32];
      t_rsp_ready[cur_sel_q] = rsp_ready;
    end else if (err_pend_q) begin
      rsp_valid = 1'b1;
      rsp_err   = 1'b1;
    end else begin
      rsp_valid = 1'b0;
    end
  end

  // Next-state for outstanding tracking and the sticky spurious-response flag.
  always_comb begin
    req_acc_s  = req_valid && req_ready;
    rsp_hs_s   = (cnt_q != 4'd0) && rsp_valid && rsp_ready;
    cnt_d      = cnt_q;
    cur_sel_d  = cur_sel_q;
    err_pend_d = err_pend_q;
    spur_hit_s = 1'b0;

    if (req_acc_s && in_range_s) begin
      cur_sel_d = sel_s;
    end else begin
      cur_sel_d = cur_sel_q;
    end

    if (req_acc_s && in_range_s && !rsp_hs_s) begin
      cnt_d = cnt_q + 4'd1;
    end else if (rsp_hs_s && !(req_acc_s && in_range_s)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (err_pend_q && rsp_ready) begin
      err_pend_d = 1'b0;
    end else if (req_acc_s && !in_range_s) begin
      err_pend_d = 1'b1;
    end else begin
      err_pend_d = err_pend_q;
    end

    for (int i = 0; i < 4; i++) begin
      if (t_rsp_valid[i] && ((cnt_q == 4'd0) || (2'(i) != cur_sel_q))) begin
        spur_hit_s = 1'b1;
      end else begin
        spur_hit_s = spur_hit_s;
      end
    end
    err_spurious_d = err_spurious_q | spur_hit_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= 4'd0;
      cur_sel_q      <= 2'd0;
      err_pend_q     <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      cur_sel_q      <= cur_sel_d;
      err_pend_q     <= err_pend_d;
      err_spurious_q <= err_spurious_d;
    end
  end

endmodule
